cache_ctrl: RTL

- Sequencing controller for the 4-way, 8-set cache.
- Accepts CPU read/write requests, evaluates per-way hit/valid status returned by the tag/valid datapath, and picks a victim with a per-set tree pseudo-LRU.
- Drives the per-way valid, tag and data array write strobes.
- Runs multi-beat line refills and write-through memory writes over a req/ack handshake.
- Sits between the CPU port and the tag/valid/data arrays plus the memory interface.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_ctrl_plru4.sv | 33 +++
 rtl/cache_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the 4-way, 8-set cache controller.
// Holds geometry parameters, derived widths, the controller state
// enum and the rule that maps (way, set) onto a valid-array strobe bit.
package cache_pkg;

  localparam int NUM_SETS   = 8;
  localparam int NUM_WAYS   = 4;   // fixed: the PLRU tree is 3 bits per set
  localparam int LINE_BEATS = 4;

  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int WAY_W   = $clog2(NUM_WAYS);
  localparam int BEAT_W  = $clog2(LINE_BEATS);
  localparam int PLRU_W  = 3;
  localparam int VALID_W = NUM_WAYS * NUM_SETS;
  localparam int VIDX_W  = $clog2(VALID_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITE_MEM = 3'd2,
    REFILL    = 3'd3,
    FILL_DONE = 3'd4,
    FLUSH     = 3'd5
  } cacheState_t;

  // Valid-array strobe bit for a given way and set: way*NUM_SETS + set.
  // NUM_SETS is a power of two, so concatenation is the same arithmetic.
  function automatic logic [VIDX_W-1:0] validIdx(input logic [WAY_W-1:0] way,
                                                 input logic [IDX_W-1:0] set);
    return {way, set};
  endfunction

endpackage

// File: rtl/cache_ctrl_plru4.sv
// Tree pseudo-LRU for one 4-way set entry {b2,b1,b0}.
// Ports:
//   bits       current PLRU bits of the set
//   accessWay  way being touched (hit or refill victim)
//   victim     way the tree currently points at for replacement
//   nextBits   PLRU bits after touching accessWay
// Purely combinational; the register file lives in cache_ctrl.
module plru4
  import cache_pkg::*;
(
  input  logic [PLRU_W-1:0] bits,
  input  logic [WAY_W-1:0]  accessWay,
  output logic [WAY_W-1:0]  victim,
  output logic [PLRU_W-1:0] nextBits
);

  always_comb begin
    // b0 picks the half, b1/b2 pick within the half.
    if (bits[0]) victim = bits[2] ? 2'd3 : 2'd2;
    else         victim = bits[1] ? 2'd1 : 2'd0;

    // Touching a way points the tree away from it; the untouched
    // half's bit is left alone.
    nextBits = bits;
    case (accessWay)
      2'd0: begin nextBits[0] = 1'b1; nextBits[1] = 1'b1; end
      2'd1: begin nextBits[0] = 1'b1; nextBits[1] = 1'b0; end
      2'd2: begin nextBits[0] = 1'b0; nextBits[2] = 1'b1; end
      default: begin nextBits[0] = 1'b0; nextBits[2] = 1'b0; end
    endcase
  end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for the 4-way, 8-set cache.
// Accepts CPU read/write requests, evaluates the per-way hit/valid status
// returned by the tag/valid datapath, selects refill victims with a per-set
// tree PLRU, drives the valid/tag/data array strobes and runs multi-beat
// refills and write-through writes on the memory req/ack handshake.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_index CPU request, held until cpu_done
//   flush_req                invalidate-all request, held until flush_done
//   hit_way, set_valid       datapath status for lk_index, meaningful in LOOKUP
//   mem_ack                  memory accepts the current beat/write
//   lk_index                 latched index to the arrays
//   cpu_done, cpu_hit        completion pulse and its hit qualifier
//   flush_done               flush completion pulse
//   valid_we, valid_bit      valid-array strobes (bit way*8+set) and data
//   tag_we, data_we          one-hot array strobes for lk_index
//   mem_req, mem_wr, mem_beat memory request, direction, refill beat
//   dbgState, dbgPlru        observation of FSM state and all PLRU entries
// Memory handshake: mem_req is held high for as long as the controller
// needs the memory; a beat or write completes in any cycle where both
// mem_req and mem_ack are high. mem_ack with mem_req low has no effect.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [IDX_W-1:0]           cpu_index,
  input  logic                       flush_req,
  input  logic [NUM_WAYS-1:0]        hit_way,
  input  logic [NUM_WAYS-1:0]        set_valid,
  input  logic                       mem_ack,
  output logic [IDX_W-1:0]           lk_index,
  output logic                       cpu_done,
  output logic                       cpu_hit,
  output logic                       flush_done,
  output logic [VALID_W-1:0]         valid_we,
  output logic                       valid_bit,
  output logic [NUM_WAYS-1:0]        tag_we,
  output logic [NUM_WAYS-1:0]        data_we,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [BEAT_W-1:0]          mem_beat,
  output cacheState_t                dbgState,
  output logic [NUM_SETS*PLRU_W-1:0] dbgPlru
);

  cacheState_t       state, stateNext;
  logic [IDX_W-1:0]  lkIndex;
  logic              lkWe;
  logic              hitLatched;
  logic [WAY_W-1:0]  victimLatched;
  logic [BEAT_W-1:0] beat;
  logic [PLRU_W-1:0] plru [NUM_SETS];

  logic              anyHit;
  logic              allValid;
  logic [WAY_W-1:0]  hitWay;
  logic [WAY_W-1:0]  freeWay;
  logic [WAY_W-1:0]  plruVictim;
  logic [WAY_W-1:0]  missVictim;
  logic [WAY_W-1:0]  plruAccess;
  logic [PLRU_W-1:0] plruNext;
  logic              plruWe;
  logic              lastBeat;

  // Lowest set bit of hit_way wins, so an illegal multi-hot hit still
  // resolves deterministically. Same scan for the lowest invalid way.
  always_comb begin
    hitWay  = '0;
    freeWay = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_way[w])    hitWay  = WAY_W'(w);
      if (!set_valid[w]) freeWay = WAY_W'(w);
    end
  end

  assign anyHit     = |hit_way;
  assign allValid   = &set_valid;
  assign missVictim = allValid ? plruVictim : freeWay;
  assign lastBeat   = (beat == BEAT_W'(LINE_BEATS - 1));

  // One PLRU datapath serves both the LOOKUP hit update and the
  // FILL_DONE victim update; its victim output is only used in LOOKUP.
  assign plruAccess = (state == FILL_DONE) ? victimLatched : hitWay;

  plru4 uPlru (
    .bits      (plru[lkIndex]),
    .accessWay (plruAccess),
    .victim    (plruVictim),
    .nextBits  (plruNext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lkIndex       <= '0;
      lkWe          <= 1'b0;
      hitLatched    <= 1'b0;
      victimLatched <= '0;
      beat          <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && !flush_req && cpu_req) begin
        lkIndex <= cpu_index;
        lkWe    <= cpu_we;
      end
      if (state == LOOKUP) begin
        hitLatched <= anyHit;
        if (!lkWe && !anyHit) victimLatched <= missVictim;
      end
      if (state == REFILL && mem_ack) begin
        beat <= lastBeat ? '0 : beat + BEAT_W'(1);
      end
      if (state == FLUSH) begin
        for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
      end else if (plruWe) begin
        plru[lkIndex] <= plruNext;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    plruWe     = 1'b0;
    cpu_done   = 1'b0;
    cpu_hit    = 1'b0;
    flush_done = 1'b0;
    valid_we   = '0;
    valid_bit  = 1'b0;
    tag_we     = '0;
    data_we    = '0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_beat   = '0;

    case (state)
      IDLE: begin
        if (flush_req)    stateNext = FLUSH;
        else if (cpu_req) stateNext = LOOKUP;
      end

      FLUSH: begin
        valid_we   = '1;
        valid_bit  = 1'b0;
        flush_done = 1'b1;
        stateNext  = IDLE;
      end

      LOOKUP: begin
        if (lkWe) begin
          // Write-through, no allocate: only a hit touches the arrays.
          if (anyHit) begin
            data_we[hitWay] = 1'b1;
            plruWe          = 1'b1;
          end
          stateNext = WRITE_MEM;
        end else if (anyHit) begin
          cpu_done  = 1'b1;
          cpu_hit   = 1'b1;
          plruWe    = 1'b1;
          stateNext = IDLE;
        end else begin
          // Invalidate the victim up front so a refill aborted by reset
          // never leaves a valid line with partially written data.
          valid_we[validIdx(missVictim, lkIndex)] = 1'b1;
          valid_bit = 1'b0;
          stateNext = REFILL;
        end
      end

      WRITE_MEM: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        if (mem_ack) begin
          cpu_done  = 1'b1;
          cpu_hit   = hitLatched;
          stateNext = IDLE;
        end
      end

      REFILL: begin
        mem_req  = 1'b1;
        mem_wr   = 1'b0;
        mem_beat = beat;
        if (mem_ack) begin
          data_we[victimLatched] = 1'b1;
          if (lastBeat) stateNext = FILL_DONE;
        end
      end

      FILL_DONE: begin
        tag_we[victimLatched] = 1'b1;
        valid_we[validIdx(victimLatched, lkIndex)] = 1'b1;
        valid_bit = 1'b1;
        plruWe    = 1'b1;
        cpu_done  = 1'b1;
        cpu_hit   = 1'b0;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

  assign lk_index = lkIndex;
  assign dbgState = state;

  always_comb begin
    dbgPlru = '0;
    for (int s = 0; s < NUM_SETS; s++) dbgPlru[s*PLRU_W +: PLRU_W] = plru[s];
  end

endmodule
